// File: rtl/tenyr_pkg.sv
// Opcode, state and reserved-op definitions shared by the tenyr execute stage.
package tenyr_pkg;

   localparam logic [3:0] OP_OR   = 4'h0;
   localparam logic [3:0] OP_AND  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_MUL  = 4'h3;
   localparam logic [3:0] OP_RSV4 = 4'h4;
   localparam logic [3:0] OP_SHL  = 4'h5;
   localparam logic [3:0] OP_SLT  = 4'h6;
   localparam logic [3:0] OP_SEQ  = 4'h7;
   localparam logic [3:0] OP_SGT  = 4'h8;
   localparam logic [3:0] OP_ANDN = 4'h9;
   localparam logic [3:0] OP_XOR  = 4'hA;
   localparam logic [3:0] OP_SUB  = 4'hB;
   localparam logic [3:0] OP_XNOR = 4'hC;
   localparam logic [3:0] OP_SHR  = 4'hD;
   localparam logic [3:0] OP_SNE  = 4'hE;
   localparam logic [3:0] OP_RSVF = 4'hF;

   // Bit n set means opcode n is reserved (4 and F).
   localparam logic [15:0] RESERVED_OP_MASK = 16'h8010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } exec_state_t;

   function automatic logic is_reserved(input logic [3:0] op);
      return RESERVED_OP_MASK[op];
   endfunction

endpackage

// File: rtl/exec_mul.sv
// Low-half WIDTH x WIDTH multiplier spread over STAGES enable-advanced registers.
module exec_mul
   import tenyr_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] prod
);

   logic [WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] stage_r [STAGES];

   // Truncated product of the live operands, loaded into the first stage.
   always_comb begin
      prod_s = x * o;
   end

   // Product pipeline; later stages only carry the first stage forward.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < STAGES; i++) stage_r[i] <= '0;
      end else if (clr) begin
         for (int i = 0; i < STAGES; i++) stage_r[i] <= '0;
      end else if (en) begin
         stage_r[0] <= prod_s;
         for (int i = 1; i < STAGES; i++) stage_r[i] <= stage_r[i-1];
      end
   end

   assign prod = stage_r[STAGES-1];

endmodule

// File: rtl/exec_pipe.sv
// Execute stage: rhs = f(X, O) + A with handshakes, multi-cycle multiply and flush.
module exec_pipe
   import tenyr_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             swap,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic [WIDTH-1:0] I,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] rhs,
   output logic             illegal
);

   localparam int MUL_STAGES = MUL_CYCLES - 1;
   localparam int CNT_W      = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MUL_STAGES - 1);
   localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

   exec_state_t      state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] a_r, rhs_r;
   logic             illegal_r;
   logic [WIDTH-1:0] o_s, a_s, f_s, alu_s, mul_prod_s;
   logic             in_ready_s, out_valid_s, accept_s, mul_start_s, mul_last_s, mul_en_s;

   assign accept_s    = in_valid & in_ready_s;
   assign mul_start_s = accept_s & ~flush & (op == OP_MUL);
   assign mul_last_s  = (state_r == ST_MUL) & (cnt_r == CNT_LAST);
   assign mul_en_s    = mul_start_s | (state_r == ST_MUL);

   exec_mul #(.WIDTH(WIDTH), .STAGES(MUL_STAGES)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush),
      .en      (mul_en_s),
      .x       (X),
      .o       (o_s),
      .prod    (mul_prod_s)
   );

   // Single-cycle operation table on the live operands; compares are signed.
   always_comb begin
      o_s = swap ? I : Y;
      a_s = swap ? Y : I;
      f_s = '0;
      case (op)
         OP_OR:   f_s = X | o_s;
         OP_AND:  f_s = X & o_s;
         OP_ADD:  f_s = X + o_s;
         OP_SHL:  f_s = (o_s >= SHIFT_LIM) ? '0 : (X << o_s);
         OP_SLT:  f_s = {WIDTH{$signed(X) < $signed(o_s)}};
         OP_SEQ:  f_s = {WIDTH{X == o_s}};
         OP_SGT:  f_s = {WIDTH{$signed(X) > $signed(o_s)}};
         OP_ANDN: f_s = X & ~o_s;
         OP_XOR:  f_s = X ^ o_s;
         OP_SUB:  f_s = X - o_s;
         OP_XNOR: f_s = X ^ ~o_s;
         OP_SHR:  f_s = (o_s >= SHIFT_LIM) ? '0 : (X >> o_s);
         OP_SNE:  f_s = {WIDTH{X != o_s}};
         default: f_s = '0;
      endcase
      if (is_reserved(op)) begin
         alu_s = '0;
      end else begin
         alu_s = f_s + a_s;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= ST_IDLE;
      else          state_r <= state_nxt_s;
   end

   // Next-state logic; flush overrides any accept or multiply progress.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (flush)         state_nxt_s = ST_IDLE;
            else if (accept_s) state_nxt_s = (op == OP_MUL) ? ST_MUL : ST_DONE;
            else               state_nxt_s = ST_IDLE;
         end
         ST_MUL: begin
            if (flush)           state_nxt_s = ST_IDLE;
            else if (mul_last_s) state_nxt_s = ST_DONE;
            else                 state_nxt_s = ST_MUL;
         end
         ST_DONE: begin
            if (flush)          state_nxt_s = ST_IDLE;
            else if (accept_s)  state_nxt_s = (op == OP_MUL) ? ST_MUL : ST_DONE;
            else if (out_ready) state_nxt_s = ST_IDLE;
            else                state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      in_ready_s  = (state_r == ST_IDLE) | ((state_r == ST_DONE) & out_ready);
      out_valid_s = (state_r == ST_DONE);
   end

   // Multiply progress counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                 cnt_r <= '0;
      else if (flush | mul_start_s) cnt_r <= '0;
      else if (mul_last_s)          cnt_r <= '0;
      else if (state_r == ST_MUL)   cnt_r <= cnt_r + 1'b1;
      else                          cnt_r <= cnt_r;
   end

   // Result registers: loaded at accept, or when the multiply pipeline drains.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rhs_r     <= '0;
         illegal_r <= 1'b0;
         a_r       <= '0;
      end else if (!flush) begin
         if (accept_s) begin
            a_r       <= a_s;
            illegal_r <= is_reserved(op);
            if (op != OP_MUL) rhs_r <= alu_s;
         end else if (mul_last_s) begin
            rhs_r <= mul_prod_s + a_r;
         end
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign rhs       = rhs_r;
   assign illegal   = illegal_r;

endmodule
